// File: rtl/key_evt_pkg.sv
// Shared types and helpers for key event classification: FSM state enum,
// ms-to-cycle conversion and the registered event payload.
package key_evt_pkg;

  localparam int unsigned PULSE_W = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } key_state_e;

  typedef struct packed {
    logic [PULSE_W-1:0] short_e;
    logic [PULSE_W-1:0] double_e;
    logic [PULSE_W-1:0] long_e;
  } key_evt_t;

  function automatic int unsigned ms2cyc(input int unsigned freq, input int unsigned ms);
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// Registers a debounced active-low key level and flags press (falling) and
// release (rising) edges combinationally against the registered copy.
module key_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_key_d,
  output logic o_press_c,
  output logic o_release_c
);

  logic r_key_d;

  // Resets to "released" so a key held through reset yields a press afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_key_d <= 1'b1;
    else        r_key_d <= i_key;
  end

  assign o_key_d     = r_key_d;
  assign o_press_c   = r_key_d & ~i_key;
  assign o_release_c = ~r_key_d & i_key;

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into single-cycle short/double/long pulses.
// Build option: KEY_AUTO_REPEAT_EN re-fires long_pulse periodically while held.
module key_event_classifier
  import key_evt_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DOUBLE_MS = 300,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_db,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic key_held,
  output logic busy
);

  localparam int unsigned LONG_CYC = ms2cyc(CLK_FREQ, LONG_MS);
  localparam int unsigned DBL_CYC  = ms2cyc(CLK_FREQ, DOUBLE_MS);
`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RPT_CYC  = ms2cyc(CLK_FREQ, REPEAT_MS);
`else
  // Without auto-repeat the repeat period plays no part in counter sizing.
  localparam int unsigned RPT_CYC  = 0 * REPEAT_MS;
`endif
  localparam int unsigned LD_MAX   = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
  localparam int unsigned CNT_MAX  = (RPT_CYC > LD_MAX) ? RPT_CYC : LD_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             w_key_d;
  logic             w_press;
  logic             w_release;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  key_evt_t         w_evt;
  key_evt_t         r_evt;
  logic             r_short_pulse;
  logic             r_double_pulse;
  logic             r_long_pulse;
  logic             r_busy;

  key_edge_det u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_key      (key_db),
    .o_key_d    (w_key_d),
    .o_press_c  (w_press),
    .o_release_c(w_release)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Edge events take priority over the coincident timeout in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_evt       = '0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_press) w_state_nxt = PRESS1;
      end
      PRESS1: begin
        if (w_release) begin
          w_state_nxt = WAIT2;
        end else if (r_cnt == CNT_W'(LONG_CYC - 1)) begin
          w_state_nxt  = LONG_HELD;
          w_evt.long_e = PULSE_W'(1);
        end
      end
      LONG_HELD: begin
        if (w_release) begin
          w_state_nxt = IDLE;
        end
`ifdef KEY_AUTO_REPEAT_EN
        else if (r_cnt == CNT_W'(RPT_CYC - 1)) begin
          w_evt.long_e = PULSE_W'(1);
          w_cnt_clr    = 1'b1;
        end
`endif
      end
      WAIT2: begin
        if (w_press) begin
          w_state_nxt = PRESS2;
        end else if (r_cnt == CNT_W'(DBL_CYC - 1)) begin
          w_state_nxt   = IDLE;
          w_evt.short_e = PULSE_W'(1);
        end
      end
      PRESS2: begin
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_evt.double_e = PULSE_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_clr = 1'b1;
  end

  // Shared timer: cleared on state change, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (w_cnt_clr)        r_cnt <= '0;
    else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Events are staged once, then presented the cycle after the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt          <= '0;
      r_short_pulse  <= 1'b0;
      r_double_pulse <= 1'b0;
      r_long_pulse   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_evt          <= w_evt;
      r_short_pulse  <= r_evt.short_e;
      r_double_pulse <= r_evt.double_e;
      r_long_pulse   <= r_evt.long_e;
      r_busy         <= (w_state_nxt != IDLE);
    end
  end

  assign short_pulse  = r_short_pulse;
  assign double_pulse = r_double_pulse;
  assign long_pulse   = r_long_pulse;
  assign key_held     = ~w_key_d;
  assign busy         = r_busy;

endmodule
